// File: rtl/fft_bank_sched_pkg.sv
// Shared types, sizes and index-mapping helpers for the 4-bank in-place FFT scheduler.
package fft_pkg;

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned ADDR_W = IDX_W - 2;
  localparam int unsigned STAGES = IDX_W / 2;
  localparam int unsigned NPTS   = 1 << IDX_W;
  localparam int unsigned NBF    = NPTS / 4;

  typedef enum logic [2:0] {
    CS_IDLE   = 3'b000,
    CS_LOAD   = 3'b001,
    CS_CALC   = 3'b010,
    CS_UNLOAD = 3'b011,
    CS_DONE   = 3'b100
  } cs_e;

  typedef enum logic [1:0] {
    SUB_RD = 2'd0,
    SUB_WT = 2'd1,
    SUB_WR = 2'd2
  } sub_e;

  // One operand's location in the banked memory.
  typedef struct packed {
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
  } bank_ref_t;

  // Base-4 digit sum mod 4: the four operands of a butterfly differ in exactly one digit.
  function automatic logic [1:0] bank_of(input logic [IDX_W-1:0] n);
    logic [1:0] acc;
    acc = 2'd0;
    for (int unsigned d = 0; d < STAGES; d++) begin
      acc = acc + n[2*d +: 2];
    end
    return acc;
  endfunction

  function automatic logic [IDX_W-1:0] digit_rev(input logic [IDX_W-1:0] j);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned d = 0; d < STAGES; d++) begin
      r[2*d +: 2] = j[2*(STAGES-1-d) +: 2];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_sched_if.sv
// Control/address bundle between the FFT scheduler and the bank routing / butterfly datapath.
interface fft_bank_sched_if;
  import fft_pkg::*;

  logic              start;
  logic              in_valid;
  logic              out_ready;
  logic [2:0]        cs;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        A_sel;
  logic [1:0]        B_sel;
  logic [1:0]        C_sel;
  logic [1:0]        D_sel;
  logic [ADDR_W-1:0] Q0_addr;
  logic [ADDR_W-1:0] Q1_addr;
  logic [ADDR_W-1:0] Q2_addr;
  logic [ADDR_W-1:0] Q3_addr;
  logic              ready;
  logic              op_wr;
  logic [IDX_W-1:0]  tw_exp;
  logic [2:0]        stage;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, out_ready,
    input  cs, cnt, A_sel, B_sel, C_sel, D_sel,
           Q0_addr, Q1_addr, Q2_addr, Q3_addr,
           ready, op_wr, tw_exp, stage, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output cs, cnt, A_sel, B_sel, C_sel, D_sel,
           Q0_addr, Q1_addr, Q2_addr, Q3_addr,
           ready, op_wr, tw_exp, stage, busy, done
  );

endinterface

// File: rtl/fft_bank_sched_bf_addr_gen.sv
// Combinational (stage, butterfly) -> four (bank, addr) operands plus twiddle exponent.
// lin_en_i overrides operand 0 with a plain sample index for load/unload.
module fft_bf_addr_gen
  import fft_pkg::*;
(
  input  logic [2:0]             stage_i,
  input  logic [ADDR_W-1:0]      bf_i,
  input  logic                   lin_en_i,
  input  logic [IDX_W-1:0]       lin_idx_i,
  output bank_ref_t [3:0]        ref_o,
  output logic [IDX_W-1:0]       tw_exp_o
);

  logic [2:0]                p;
  logic [3:0]                sh_p;
  logic [3:0]                sh_s;
  logic [IDX_W-1:0]          mask;
  logic [IDX_W-1:0]          bf_ext;
  logic [IDX_W-1:0]          base;
  logic [3:0][IDX_W-1:0]     n_k;

  // Insert a zero digit at position p; operands then fill that digit with 0..3.
  always_comb begin
    p        = 3'(STAGES - 1) - stage_i;
    sh_p     = {p, 1'b0};
    sh_s     = {stage_i, 1'b0};
    bf_ext   = IDX_W'(bf_i);
    mask     = (IDX_W'(1) << sh_p) - IDX_W'(1);
    base     = ((bf_ext & ~mask) << 2) | (bf_ext & mask);
    tw_exp_o = (bf_ext & mask) << sh_s;
    for (int k = 0; k < 4; k++) begin
      n_k[k] = base | (IDX_W'(k) << sh_p);
    end
    if (lin_en_i) begin
      n_k[0] = lin_idx_i;
    end
    for (int k = 0; k < 4; k++) begin
      ref_o[k].sel  = bank_of(n_k[k]);
      ref_o[k].addr = n_k[k][IDX_W-1:2];
    end
  end

endmodule

// File: rtl/fft_bank_sched.sv
// Stage/butterfly scheduler for the 4-bank in-place FFT memory (load, radix-4 passes, unload).
// Define FFT_SCHED_DIGITREV_EN to unload in digit-reversed (natural frequency) order.
module fft_bank_sched
  import fft_pkg::*;
#(
  parameter int unsigned BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  fft_bank_sched_if.slave  io
);

  localparam int unsigned      WT_W    = (BF_LAT > 2) ? $clog2(BF_LAT) : 1;
  localparam logic [WT_W-1:0]  WT_LAST = WT_W'((BF_LAT > 1) ? (BF_LAT - 2) : 0);

  cs_e                 cs_q, cs_d;
  sub_e                sub_q, sub_d;
  logic [WT_W-1:0]     wt_q, wt_d;
  logic [2:0]          stage_q, stage_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  bank_ref_t [3:0]     ref_q, ref_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    tw_exp_q, tw_exp_d;
  logic                ready_q, ready_d;
  logic                op_wr_q, op_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                lin_en;
  logic [IDX_W-1:0]    lin_idx;
  bank_ref_t [3:0]     gen_ref;
  logic [IDX_W-1:0]    gen_tw;

  logic                last_idx;
  logic                last_bf;
  logic                last_stage;

  assign last_idx   = (idx_q == IDX_W'(NPTS - 1));
  assign last_bf    = (idx_q[ADDR_W-1:0] == ADDR_W'(NBF - 1));
  assign last_stage = (stage_q == 3'(STAGES - 1));

  // Phase / substate sequencing; idx holds i (LOAD), b (CALC) or j (UNLOAD).
  always_comb begin
    cs_d    = cs_q;
    sub_d   = sub_q;
    wt_d    = wt_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    unique case (cs_q)
      CS_IDLE: begin
        sub_d   = SUB_RD;
        wt_d    = '0;
        stage_d = '0;
        idx_d   = '0;
        if (io.start) begin
          cs_d = CS_LOAD;
        end
      end
      CS_LOAD: begin
        if (io.in_valid) begin
          if (last_idx) begin
            cs_d    = CS_CALC;
            sub_d   = SUB_RD;
            stage_d = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CS_CALC: begin
        case (sub_q)
          SUB_RD: begin
            if (BF_LAT > 1) begin
              sub_d = SUB_WT;
              wt_d  = WT_LAST;
            end else begin
              sub_d = SUB_WR;
            end
          end
          SUB_WT: begin
            if (wt_q == '0) begin
              sub_d = SUB_WR;
            end else begin
              wt_d = wt_q - WT_W'(1);
            end
          end
          SUB_WR: begin
            sub_d = SUB_RD;
            if (last_bf) begin
              idx_d = '0;
              if (last_stage) begin
                cs_d    = CS_UNLOAD;
                stage_d = '0;
              end else begin
                stage_d = stage_q + 3'd1;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          default: sub_d = SUB_RD;
        endcase
      end
      CS_UNLOAD: begin
        if (io.out_ready) begin
          if (last_idx) begin
            cs_d  = CS_DONE;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CS_DONE: begin
        cs_d = CS_IDLE;
      end
      default: cs_d = CS_IDLE;
    endcase
  end

  // Address generator looks at next state so that the output flops line up with cs_q.
  always_comb begin
    lin_en = (cs_d == CS_LOAD) || (cs_d == CS_UNLOAD);
`ifdef FFT_SCHED_DIGITREV_EN
    lin_idx = (cs_d == CS_UNLOAD) ? digit_rev(idx_d) : idx_d;
`else
    lin_idx = idx_d;
`endif
  end

  fft_bf_addr_gen u_addr_gen (
    .stage_i   (stage_d),
    .bf_i      (idx_d[ADDR_W-1:0]),
    .lin_en_i  (lin_en),
    .lin_idx_i (lin_idx),
    .ref_o     (gen_ref),
    .tw_exp_o  (gen_tw)
  );

  always_comb begin
    ref_d    = '0;
    cnt_d    = '0;
    tw_exp_d = '0;
    ready_d  = (cs_d == CS_CALC) && (sub_d == SUB_RD);
    op_wr_d  = (cs_d == CS_CALC) && (sub_d == SUB_WR);
    busy_d   = (cs_d != CS_IDLE);
    done_d   = (cs_d == CS_DONE);
    case (cs_d)
      CS_CALC: begin
        ref_d    = gen_ref;
        tw_exp_d = gen_tw;
      end
      CS_LOAD, CS_UNLOAD: begin
        ref_d[0] = gen_ref[0];
        cnt_d    = gen_ref[0].addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q     <= CS_IDLE;
      sub_q    <= SUB_RD;
      wt_q     <= '0;
      stage_q  <= '0;
      idx_q    <= '0;
      ref_q    <= '0;
      cnt_q    <= '0;
      tw_exp_q <= '0;
      ready_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cs_q     <= cs_d;
      sub_q    <= sub_d;
      wt_q     <= wt_d;
      stage_q  <= stage_d;
      idx_q    <= idx_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      tw_exp_q <= tw_exp_d;
      ready_q  <= ready_d;
      op_wr_q  <= op_wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign io.cs      = cs_q;
  assign io.cnt     = cnt_q;
  assign io.A_sel   = ref_q[0].sel;
  assign io.B_sel   = ref_q[1].sel;
  assign io.C_sel   = ref_q[2].sel;
  assign io.D_sel   = ref_q[3].sel;
  assign io.Q0_addr = ref_q[0].addr;
  assign io.Q1_addr = ref_q[1].addr;
  assign io.Q2_addr = ref_q[2].addr;
  assign io.Q3_addr = ref_q[3].addr;
  assign io.tw_exp  = tw_exp_q;
  assign io.stage   = stage_q;
  assign io.busy    = busy_q;
  assign io.done    = done_q;

  // Sample writes and result reads must strobe in the same cycle as their handshake input.
  assign io.op_wr = op_wr_q | ((cs_q == CS_LOAD) & io.in_valid);
  assign io.ready = ready_q | ((cs_q == CS_UNLOAD) & io.out_ready);

endmodule

// File: tb/tb_fft_bank_sched.sv
// Directed self-checking bench for fft_bank_sched: load, full CALC sweep, unload, mid-frame reset.
module tb_fft_bank_sched;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft_bank_sched_if io ();

  fft_bank_sched #(.BF_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  function automatic int bank_m(input int n);
    int acc = 0;
    int v = n;
    for (int d = 0; d < 5; d++) begin
      acc = acc + (v % 4);
      v = v / 4;
    end
    return acc % 4;
  endfunction

  function automatic int rev_m(input int j);
    int r = 0;
    int v = j;
    for (int d = 0; d < 5; d++) begin
      r = r * 4 + (v % 4);
      v = v / 4;
    end
    return r;
  endfunction

  function automatic int opnd_m(input int s, input int b, input int k);
    int pw = 1 << (2 * (4 - s));
    return (b / pw) * pw * 4 + (b % pw) + k * pw;
  endfunction

  function automatic int tw_m(input int s, input int b);
    int pw = 1 << (2 * (4 - s));
    return (b % pw) * (1 << (2 * s));
  endfunction

  function automatic int order_m(input int j);
`ifdef FFT_SCHED_DIGITREV_EN
    return rev_m(j);
`else
    return j;
`endif
  endfunction

  task automatic test_reset();
    logic [39:0] act_v;
    act_v = {io.A_sel, io.B_sel, io.C_sel, io.D_sel, io.Q0_addr, io.Q1_addr, io.Q2_addr, io.Q3_addr};
    n_cmp++;
    if (io.cs !== 3'b000) begin n_err++; $display("FAIL reset_cs got %b want 000", io.cs); end
    n_cmp++;
    if (act_v !== 40'd0) begin n_err++; $display("FAIL reset_sel_addr got %h want 0", act_v); end
    n_cmp++;
    if ({io.cnt, io.tw_exp, io.stage} !== 21'd0) begin
      n_err++; $display("FAIL reset_cnt_tw_stage got %0d/%0d/%0d want 0/0/0", io.cnt, io.tw_exp, io.stage);
    end
    n_cmp++;
    if ({io.ready, io.op_wr, io.busy, io.done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes got %b want 0000", {io.ready, io.op_wr, io.busy, io.done});
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    n_cmp++;
    if (io.cs !== 3'b001 || io.busy !== 1'b1) begin
      n_err++; $display("FAIL load_enter got cs=%b busy=%b want 001/1", io.cs, io.busy);
    end
    for (int i = 0; i < 1024; i++) begin
      if (i == 7) begin
        // Gap in in_valid (with a stray start) must hold the load position.
        io.in_valid = 1'b0;
        io.start = 1'b1;
        #1;
        n_cmp++;
        if (io.op_wr !== 1'b0 || io.cnt !== 8'd1) begin
          n_err++; $display("FAIL load_gap got op_wr=%b cnt=%0d want 0/1", io.op_wr, io.cnt);
        end
        @(negedge clk);
        io.start = 1'b0;
        n_cmp++;
        if (io.cs !== 3'b001) begin n_err++; $display("FAIL load_start_ignored got cs=%b want 001", io.cs); end
      end
      io.in_valid = 1'b1;
      #1;
      n_cmp++;
      if (io.A_sel !== 2'(bank_m(i)) || io.Q0_addr !== 8'(i / 4) || io.cnt !== 8'(i / 4) || io.op_wr !== 1'b1) begin
        n_err++;
        $display("FAIL load_map i=%0d got sel=%0d addr=%0d cnt=%0d op_wr=%b want %0d/%0d/%0d/1",
                 i, io.A_sel, io.Q0_addr, io.cnt, io.op_wr, bank_m(i), i / 4, i / 4);
      end
      if (i == 5) begin
        n_cmp++;
        if (io.A_sel !== 2'd2 || io.Q0_addr !== 8'd1) begin
          n_err++; $display("FAIL load_n5 got sel=%0d addr=%0d want 2/1", io.A_sel, io.Q0_addr);
        end
      end
      if (i == 1023) begin
        n_cmp++;
        if (io.A_sel !== 2'd3 || io.Q0_addr !== 8'd255) begin
          n_err++; $display("FAIL load_last got sel=%0d addr=%0d want 3/255", io.A_sel, io.Q0_addr);
        end
      end
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (io.cs !== 3'b010) begin n_err++; $display("FAIL load_to_calc got cs=%b want 010", io.cs); end
  endtask

  task automatic test_calc();
    logic [39:0] act_v;
    logic [39:0] exp_v;
    logic [3:0]  seen;
    int n;
    for (int s = 0; s < 5; s++) begin
      for (int b = 0; b < 256; b++) begin
        for (int c = 0; c < 4; c++) begin
          act_v = {io.A_sel, io.B_sel, io.C_sel, io.D_sel, io.Q0_addr, io.Q1_addr, io.Q2_addr, io.Q3_addr};
          for (int k = 0; k < 4; k++) begin
            n = opnd_m(s, b, k);
            exp_v[39-2*k -: 2] = 2'(bank_m(n));
            exp_v[31-8*k -: 8] = 8'(n / 4);
          end
          n_cmp++;
          if (io.ready !== (c == 0) || io.op_wr !== (c == 3)) begin
            n_err++;
            $display("FAIL calc_strobe s=%0d b=%0d c=%0d got ready=%b op_wr=%b want %b/%b",
                     s, b, c, io.ready, io.op_wr, c == 0, c == 3);
          end
          n_cmp++;
          if (act_v !== exp_v) begin
            n_err++; $display("FAIL calc_map s=%0d b=%0d c=%0d got %h want %h", s, b, c, act_v, exp_v);
          end
          n_cmp++;
          if (io.tw_exp !== 10'(tw_m(s, b)) || io.stage !== 3'(s) || io.cs !== 3'b010) begin
            n_err++;
            $display("FAIL calc_tw_stage s=%0d b=%0d got tw=%0d stage=%0d cs=%b want %0d/%0d/010",
                     s, b, io.tw_exp, io.stage, io.cs, tw_m(s, b), s);
          end
          if (c == 0) begin
            seen = (4'd1 << io.A_sel) | (4'd1 << io.B_sel) | (4'd1 << io.C_sel) | (4'd1 << io.D_sel);
            n_cmp++;
            if (seen !== 4'hF) begin
              n_err++; $display("FAIL calc_conflict s=%0d b=%0d got banks %b want 1111", s, b, seen);
            end
          end
          if (c == 0 && s == 0 && b == 0) begin
            n_cmp++;
            if (act_v !== {2'd0, 2'd1, 2'd2, 2'd3, 8'd0, 8'd64, 8'd128, 8'd192} || io.tw_exp !== 10'd0) begin
              n_err++; $display("FAIL calc_s0b0 got %h tw=%0d want 1b0040 80c0 tw=0", act_v, io.tw_exp);
            end
          end
          if (c == 0 && s == 4 && b == 1) begin
            n_cmp++;
            if (act_v !== {2'd1, 2'd2, 2'd3, 2'd0, 8'd1, 8'd1, 8'd1, 8'd1}) begin
              n_err++; $display("FAIL calc_s4b1 got %h want sels 1230 addrs 1111", act_v);
            end
          end
          @(negedge clk);
        end
      end
    end
    n_cmp++;
    if (io.cs !== 3'b011) begin n_err++; $display("FAIL calc_to_unload got cs=%b want 011", io.cs); end
  endtask

  task automatic test_unload();
    int j = 0;
    int n;
    for (int cyc = 0; cyc < 1100 && j < 1024; cyc++) begin
      io.out_ready = (cyc == 1 || cyc == 2 || cyc == 600) ? 1'b0 : 1'b1;
      #1;
      n = order_m(j);
      n_cmp++;
      if (io.A_sel !== 2'(bank_m(n)) || io.Q0_addr !== 8'(n / 4) || io.cnt !== 8'(n / 4) ||
          io.ready !== io.out_ready) begin
        n_err++;
        $display("FAIL unload_map j=%0d got sel=%0d addr=%0d cnt=%0d ready=%b want %0d/%0d/%0d/%b",
                 j, io.A_sel, io.Q0_addr, io.cnt, io.ready, bank_m(n), n / 4, n / 4, io.out_ready);
      end
      if (j == 1) begin
        n_cmp++;
`ifdef FFT_SCHED_DIGITREV_EN
        if (io.A_sel !== 2'd1 || io.cnt !== 8'd64) begin
          n_err++; $display("FAIL unload_j1 got sel=%0d cnt=%0d want 1/64", io.A_sel, io.cnt);
        end
`else
        if (io.A_sel !== 2'd1 || io.cnt !== 8'd0) begin
          n_err++; $display("FAIL unload_j1 got sel=%0d cnt=%0d want 1/0", io.A_sel, io.cnt);
        end
`endif
      end
      if (io.out_ready) j++;
      @(negedge clk);
    end
    io.out_ready = 1'b0;
    n_cmp++;
    if (j != 1024) begin n_err++; $display("FAIL unload_timeout got j=%0d want 1024", j); end
    #1;
    n_cmp++;
    if (io.cs !== 3'b100 || io.done !== 1'b1 || io.busy !== 1'b1) begin
      n_err++; $display("FAIL unload_done got cs=%b done=%b busy=%b want 100/1/1", io.cs, io.done, io.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (io.cs !== 3'b000 || io.done !== 1'b0 || io.busy !== 1'b0) begin
      n_err++; $display("FAIL done_single_pulse got cs=%b done=%b busy=%b want 000/0/0", io.cs, io.done, io.busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    io.in_valid = 1'b1;
    repeat (1024) @(negedge clk);
    io.in_valid = 1'b0;
    repeat (2 * 256 * 4 + 9) @(negedge clk);
    n_cmp++;
    if (io.cs !== 3'b010 || io.stage !== 3'd2) begin
      n_err++; $display("FAIL midcalc_pos got cs=%b stage=%0d want 010/2", io.cs, io.stage);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (io.cs !== 3'b000 || io.ready !== 1'b0 || io.op_wr !== 1'b0 || io.busy !== 1'b0 || io.stage !== 3'd0) begin
      n_err++;
      $display("FAIL midcalc_rst got cs=%b ready=%b op_wr=%b busy=%b stage=%0d want 000/0/0/0/0",
               io.cs, io.ready, io.op_wr, io.busy, io.stage);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    io.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (io.cs !== 3'b001 || io.A_sel !== 2'd0 || io.Q0_addr !== 8'd0 || io.op_wr !== 1'b1) begin
      n_err++; $display("FAIL reload_i0 got cs=%b sel=%0d addr=%0d op_wr=%b want 001/0/0/1",
                        io.cs, io.A_sel, io.Q0_addr, io.op_wr);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (io.A_sel !== 2'd1 || io.Q0_addr !== 8'd0) begin
      n_err++; $display("FAIL reload_i1 got sel=%0d addr=%0d want 1/0", io.A_sel, io.Q0_addr);
    end
    io.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    io.start = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_load();
    test_calc();
    test_unload();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_bank_sched.md
# fft_bank_sched

Stage/butterfly scheduler for the 4-bank in-place FFT memory. It sequences sample load, STAGES radix-4 compute passes and result unload. For every memory access it generates the per-operand bank selects, bank addresses, read strobe, write strobe and twiddle exponent consumed by the bank routing muxes and the butterfly datapath. Bank mapping is conflict-free: the four operands of any butterfly always land in four distinct banks.

## Interface
- IDX_W, 10, sample index width (N = 2^IDX_W = 1024)
- ADDR_W, 8, bank address width (IDX_W-2)
- STAGES, 5, radix-4 passes (IDX_W/2)
- BF_LAT, 3, cycles from read strobe to butterfly result valid at RAM inputs (>=1)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- in_valid  in  1  one input sample present this cycle (LOAD only)
- out_ready  in  1  downstream accepts one result this cycle (UNLOAD only)
- cs  out  3  phase: 000 IDLE, 001 LOAD, 010 CALC, 011 UNLOAD, 100 DONE
- cnt  out  ADDR_W  load/unload address (sample index >> 2)
- A_sel, B_sel, C_sel, D_sel  out  2 each  bank of operand 0..3
- Q0_addr..Q3_addr  out  ADDR_W each  bank address of operand 0..3
- ready  out  1  read strobe; data appears on the RAM outputs next cycle
- op_wr  out  1  write strobe for butterfly results (in place)
- tw_exp  out  IDX_W  twiddle exponent for the current butterfly
- stage  out  3  current pass, 0..STAGES-1
- busy  out  1  cs != IDLE
- done  out  1  one-cycle pulse after last unload

## Operation
- Mapping: index n → bank(n) = (sum of base-4 digits of n) mod 4; addr(n) = n >> 2.
- IDLE: start → LOAD; all counters cleared.
- LOAD: each in_valid writes sample i (i = 0..N-1): A_sel = bank(i), Q0_addr = cnt = addr(i), op_wr = 1 in that cycle. After i = N-1 → CALC, stage = 0, b = 0. No in_valid → hold.
- CALC, pass s, butterfly b (0..N/4-1):
  - p = STAGES-1-s.
  - base = b with two zero bits inserted at digit position p.
  - Operand k uses n_k = base + k·4^p.
  - Operand k drives sel_k = bank(n_k) and Qk_addr = addr(n_k).
  - tw_exp = (base mod 4^p) << 2s.
  - Substates: RD (ready = 1) → WT (BF_LAT-1 cycles) → WR (op_wr = 1).
  - Selects, addresses and tw_exp are held constant from RD through WR.
  - After WR, b increments. On b wrap, stage increments. After the last stage → UNLOAD, j = 0.
- UNLOAD: for j = 0..N-1, n = order(j): A_sel = bank(n), Q0_addr = cnt = addr(n). ready pulses when out_ready = 1, then j advances. After j = N-1 → DONE.
- DONE: done = 1 for one cycle → IDLE.
- start is ignored while busy. in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.

## Timing
- Reset values: cs = 000, all selects/addresses/cnt/tw_exp/stage = 0, ready = op_wr = busy = done = 0.
- Phase transitions:
  - start sampled at edge t → cs = LOAD from t+1.
  - Last in_valid at t → CALC at t+1.
- Butterfly period = BF_LAT+1 cycles: ready at t, op_wr at t+BF_LAT, next ready at t+BF_LAT+1.
- CALC length = STAGES·(N/4)·(BF_LAT+1) cycles.
- ready and op_wr never assert in the same cycle.
- UNLOAD: one result per cycle at full rate. out_ready low freezes j and addresses.
- rst asserted mid-frame → immediate return to reset values. Partial writes are abandoned.

## Configuration
- FFT_SCHED_DIGITREV_EN defined: unload order(j) = base-4 digit reversal of j, giving natural frequency order at the output.
- Undefined: order(j) = j, i.e. memory order. Downstream then owns the reordering.

## Structure
- Shared package fft_pkg:
  - cs encodings.
  - IDX_W/ADDR_W/STAGES defaults.
  - Functions bank_of(n) (digit sum mod 4) and digit_rev(j).
- One sub-module, fft_bf_addr_gen: combinational (s, b) → four (bank, addr) pairs plus tw_exp. It is reused for the UNLOAD mapping via operand 0.

## Test plan
- Load n = 5 → A_sel = 2, Q0_addr = 1, op_wr = 1. After 1024 in_valid, cs = 010 next cycle.
- Stage 0, b = 0 → sels 0, 1, 2, 3; addrs 0, 64, 128, 192; tw_exp = 0.
- Stage 4, b = 1 → n = 4, 5, 6, 7; sels 1, 2, 3, 0; all addrs 1.
- BF_LAT = 3 → ready at t, op_wr at t+3, ready at t+4. Addresses are stable across the whole period, and sels are pairwise distinct for every butterfly of every stage (exhaustive check).
- With FFT_SCHED_DIGITREV_EN, j = 1 → n = 256 → A_sel = 1, cnt = 64. Toggling out_ready stalls j. done pulses once after j = 1023.
- rst mid-CALC (stage 2) → cs = 000, ready = op_wr = 0. A fresh start then reloads from i = 0.
